// File: rtl/stoch_decoder.sv
// Stochastic-to-binary decoder: counts ones over a window of 2^WINDOW_BITS qualified
// samples and holds the count in a one-entry valid/ready output register.
module stoch_decoder #(
  parameter int WINDOW_BITS  = 8,
  parameter int AUTO_RESTART = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 a,
  input  logic                 a_valid,
  output logic [WINDOW_BITS:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                 state_q, state_d;
  logic [WINDOW_BITS:0]   ones_q, ones_d;
  logic [WINDOW_BITS-1:0] samples_q, samples_d;
  logic [WINDOW_BITS:0]   y_q, y_d;
  logic                   y_valid_q, y_valid_d;
  logic                   overrun_q, overrun_d;
  logic [WINDOW_BITS:0]   a_ext;
  logic [WINDOW_BITS:0]   ones_next;

  assign a_ext     = {{WINDOW_BITS{1'b0}}, a};
  assign ones_next = ones_q + a_ext;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      samples_q <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      samples_q <= samples_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    samples_d = samples_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = overrun_q;

    // Consumption first; a load in the same cycle overrides it below.
    if (y_valid_q && y_ready) y_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COUNT;
          ones_d    = '0;
          samples_d = '0;
          overrun_d = 1'b0;
        end
      end
      COUNT: begin
        if (stop) begin
          state_d   = IDLE;
          ones_d    = '0;
          samples_d = '0;
        end else if (a_valid) begin
          if (samples_q == '1) begin
            if (!y_valid_q || y_ready) begin
              y_d       = ones_next;
              y_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            ones_d    = '0;
            samples_d = '0;
            if (AUTO_RESTART == 0) state_d = IDLE;
          end else begin
            ones_d    = ones_next;
            samples_d = samples_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == COUNT);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_stoch_decoder.sv
// Directed bench for stoch_decoder with L = 16: one instance without auto-restart,
// one with auto-restart, checked against hand-computed window counts.
module tb_stoch_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r0, st0, sp0, a0, v0, rdy0, yv0, b0, o0;
  logic [4:0] y0;
  logic       r1, st1, sp1, a1, v1, rdy1, yv1, b1, o1;
  logic [4:0] y1;

  stoch_decoder #(.WINDOW_BITS(4), .AUTO_RESTART(0)) u0 (
    .CLK(clk), .RST(r0), .start(st0), .stop(sp0), .a(a0), .a_valid(v0),
    .y(y0), .y_valid(yv0), .y_ready(rdy0), .busy(b0), .overrun(o0)
  );

  stoch_decoder #(.WINDOW_BITS(4), .AUTO_RESTART(1)) u1 (
    .CLK(clk), .RST(r1), .start(st1), .stop(sp1), .a(a1), .a_valid(v1),
    .y(y1), .y_valid(yv1), .y_ready(rdy1), .busy(b1), .overrun(o1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] bits;
    bit          gap;
    int          exp_y;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lat;
    int q;

    tbl[0] = '{bits: 16'h0000, gap: 1'b0, exp_y: 0};
    tbl[1] = '{bits: 16'hAAAA, gap: 1'b0, exp_y: 8};
    tbl[2] = '{bits: 16'h0001, gap: 1'b0, exp_y: 1};
    tbl[3] = '{bits: 16'h7FFF, gap: 1'b1, exp_y: 15};
    tbl[4] = '{bits: 16'hF0F0, gap: 1'b1, exp_y: 8};
    tbl[5] = '{bits: 16'h8000, gap: 1'b1, exp_y: 1};
    tbl[6] = '{bits: 16'h00FF, gap: 1'b0, exp_y: 8};

    {r0, st0, sp0, a0, v0} = '0; rdy0 = 1'b1;
    {r1, st1, sp1, a1, v1, rdy1} = '0;
    r0 = 1'b1; r1 = 1'b1;
    tick(); tick();
    chk("rst_y0", y0, 0);     chk("rst_yv0", yv0, 0);
    chk("rst_busy0", b0, 0);  chk("rst_ovr0", o0, 0);
    chk("rst_y1", y1, 0);     chk("rst_busy1", b1, 0);
    r0 = 1'b0; r1 = 1'b0;

    // stop in IDLE has no effect
    sp0 = 1'b1; tick(); sp0 = 1'b0;
    chk("idle_stop_busy", b0, 0);

    // Table: the bit on the start cycle is 1 and must not be counted
    for (int e = 0; e < 7; e++) begin
      st0 = 1'b1; a0 = 1'b1; v0 = 1'b1; tick(); st0 = 1'b0;
      chk("tbl_busy_start", b0, 1);
      for (int i = 0; i < 16; i++) begin
        a0 = tbl[e].bits[i]; v0 = 1'b1; tick();
        if (tbl[e].gap && i < 15 && (i % 2) == 1) begin
          a0 = 1'b1; v0 = 1'b0; tick();
        end
        if (i == 14) chk("tbl_yv_early", yv0, 0);
      end
      chk("tbl_y", y0, tbl[e].exp_y);
      chk("tbl_yv", yv0, 1);
      chk("tbl_busy_end", b0, 0);
      v0 = 1'b0; tick();
      chk("tbl_yv_pulse", yv0, 0);
    end

    // Full scale latency
    st0 = 1'b1; a0 = 1'b1; v0 = 1'b1; tick(); st0 = 1'b0;
    lat = 1;
    while (!yv0 && lat < 40) begin tick(); lat++; end
    chk("fs_latency", lat, 17);
    chk("fs_y", y0, 16);
    chk("fs_busy", b0, 0);
    v0 = 1'b0; tick();
    chk("fs_yv_pulse", yv0, 0);

    // Gapped input: a_valid low every third cycle with a=1
    st0 = 1'b1; a0 = 1'b0; v0 = 1'b0; tick(); st0 = 1'b0;
    q = 0;
    for (int c = 0; c < 23; c++) begin
      if ((c % 3) == 2) begin v0 = 1'b0; a0 = 1'b1; end
      else begin v0 = 1'b1; a0 = ((q % 2) == 0); q++; end
      tick();
      if (c == 21) chk("gap_yv_early", yv0, 0);
    end
    chk("gap_y", y0, 8);
    chk("gap_yv", yv0, 1);
    v0 = 1'b0; tick();

    // Abort after 7 samples
    st0 = 1'b1; tick(); st0 = 1'b0;
    for (int i = 0; i < 7; i++) begin a0 = 1'b1; v0 = 1'b1; tick(); end
    sp0 = 1'b1; tick(); sp0 = 1'b0; v0 = 1'b0;
    chk("abort_busy", b0, 0);
    chk("abort_yv", yv0, 0);
    chk("abort_y", y0, 8);

    // start during COUNT must not restart the window
    st0 = 1'b1; tick(); st0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a0 = 1'b1; v0 = 1'b1; st0 = (i == 5); tick();
    end
    st0 = 1'b0;
    chk("ign_start_yv", yv0, 1);
    chk("ign_start_y", y0, 16);
    v0 = 1'b0; tick();

    // stop on the completion cycle wins
    st0 = 1'b1; tick(); st0 = 1'b0;
    for (int i = 0; i < 15; i++) begin a0 = 1'b0; v0 = 1'b1; tick(); end
    sp0 = 1'b1; a0 = 1'b0; v0 = 1'b1; tick(); sp0 = 1'b0; v0 = 1'b0;
    chk("stopc_busy", b0, 0);
    chk("stopc_yv", yv0, 0);
    chk("stopc_y", y0, 16);

    // Reset mid-operation with a held result
    rdy0 = 1'b0;
    st0 = 1'b1; tick(); st0 = 1'b0;
    for (int i = 0; i < 13; i++) begin a0 = (i < 11); v0 = 1'b1; tick(); end
    for (int i = 0; i < 3; i++) begin a0 = 1'b0; v0 = 1'b1; tick(); end
    chk("mid_pre_y", y0, 11);
    chk("mid_pre_yv", yv0, 1);
    st0 = 1'b1; v0 = 1'b0; tick(); st0 = 1'b0;
    for (int i = 0; i < 8; i++) begin a0 = 1'b1; v0 = 1'b1; tick(); end
    r0 = 1'b1; v0 = 1'b0; tick(); r0 = 1'b0;
    chk("mid_rst_y", y0, 0);   chk("mid_rst_yv", yv0, 0);
    chk("mid_rst_busy", b0, 0); chk("mid_rst_ovr", o0, 0);
    st0 = 1'b1; tick(); st0 = 1'b0;
    for (int i = 0; i < 16; i++) begin a0 = 1'b1; v0 = 1'b1; tick(); end
    chk("mid_post_y", y0, 16);
    chk("mid_post_yv", yv0, 1);
    v0 = 1'b0;

    // Overrun with auto-restart, consumer stalled
    st1 = 1'b1; a1 = 1'b1; v1 = 1'b1; tick(); st1 = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("ovr_w1_y", y1, 16);  chk("ovr_w1_yv", yv1, 1);
    chk("ovr_w1_ovr", o1, 0); chk("ovr_w1_busy", b1, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("ovr_w2_pre", o1, 0);
    tick();
    chk("ovr_w2_ovr", o1, 1); chk("ovr_w2_y", y1, 16);
    chk("ovr_w2_yv", yv1, 1);
    rdy1 = 1'b1; tick(); rdy1 = 1'b0;
    chk("ovr_drain_yv", yv1, 0);
    chk("ovr_sticky", o1, 1);
    sp1 = 1'b1; tick(); sp1 = 1'b0;
    chk("ovr_stop_busy", b1, 0);
    chk("ovr_stop_ovr", o1, 1);

    // Accepted start clears overrun; simultaneous consume and load
    st1 = 1'b1; a1 = 1'b1; v1 = 1'b1; tick(); st1 = 1'b0;
    chk("sim_start_ovr", o1, 0);
    for (int i = 0; i < 16; i++) tick();
    chk("sim_w1_y", y1, 16); chk("sim_w1_yv", yv1, 1);
    a1 = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rdy1 = 1'b1; tick(); rdy1 = 1'b0;
    chk("sim_w2_y", y1, 0);   chk("sim_w2_yv", yv1, 1);
    chk("sim_w2_ovr", o1, 0);
    a1 = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("sim_w3_ovr", o1, 1);
    chk("sim_w3_y", y1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
